// File: rtl/obi_arb_pkg.sv
// Arbiter-local types: master index container, FSM state, effective weight helper.
package obi_arb_pkg;

    localparam int unsigned MasterIdW = 8;

    typedef logic [MasterIdW-1:0] master_id_t;

    typedef enum logic {
        ARB  = 1'b0,
        HOLD = 1'b1
    } arb_state_e;

    // A weight of zero would starve a master, so it is promoted to one grant.
    function automatic logic [31:0] eff_weight(input logic [31:0] w);
        return (w == 32'd0) ? 32'd1 : w;
    endfunction

endpackage

// File: rtl/obi_pkg.sv
// OBI request/response structures shared by masters, arbiter and crossbar.
package obi_pkg;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;

endpackage

// File: rtl/obi_arb_id_fifo.sv
// Synchronous FIFO holding the master index of each outstanding transaction.
module obi_arb_id_fifo #(
    parameter int unsigned Width = 2,
    parameter int unsigned Depth = 4,
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1,
    localparam int unsigned CntW = $clog2(Depth + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CntW-1:0]  count_o
);

    logic [Width-1:0] r_mem [Depth];
    logic [PtrW-1:0]  r_wr_ptr;
    logic [PtrW-1:0]  r_rd_ptr;
    logic [CntW-1:0]  r_count;
    logic             w_push;
    logic             w_pop;

    assign full_o  = (r_count == CntW'(Depth));
    assign empty_o = (r_count == '0);
    assign count_o = r_count;
    assign data_o  = r_mem[r_rd_ptr];
    assign w_push  = push_i & ~full_o;
    assign w_pop   = pop_i & ~empty_o;

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == PtrW'(Depth - 1)) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PtrW'(Depth - 1)) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CntW'(1);
                2'b01:   r_count <= r_count - CntW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/obi_wrr_arbiter.sv
// N-to-1 weighted round-robin OBI arbiter with in-order response routing.
// Optional per-master grant counters are enabled by OBI_WRR_ARBITER_PERF_CNT_EN.
module obi_wrr_arbiter
    import obi_pkg::*;
    import obi_arb_pkg::*;
#(
    parameter int unsigned NumMasters     = 3,
    parameter int unsigned MaxOutstanding = 4,
    parameter int unsigned WeightWidth    = 4,
    localparam int unsigned IdW           = $clog2(NumMasters),
    localparam int unsigned CntW          = $clog2(MaxOutstanding + 1)
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [NumMasters*WeightWidth-1:0] weight_i,
    input  obi_req_t  [NumMasters-1:0]        master_req_i,
    output obi_resp_t [NumMasters-1:0]        master_resp_o,
    output obi_req_t                          slave_req_o,
    input  obi_resp_t                         slave_resp_i,
    output logic                              busy_o,
    output logic                              err_o
`ifdef OBI_WRR_ARBITER_PERF_CNT_EN
    ,
    output logic [NumMasters*32-1:0]          grant_cnt_o
`endif
);

    arb_state_e             r_state;
    arb_state_e             w_state_next;
    logic [IdW-1:0]         r_ptr;
    logic [IdW-1:0]         r_lock_id;
    logic [WeightWidth-1:0] r_credit;
    logic                   r_err;

    logic [IdW-1:0]         w_winner;
    logic                   w_has_winner;
    logic                   w_hs;
    logic                   w_full;
    logic                   w_empty;
    logic [IdW-1:0]         w_head;
    logic [CntW-1:0]        w_count;
    logic [WeightWidth-1:0] w_weight;
    logic [WeightWidth-1:0] w_credit_use;

    // Lowest offset from r_ptr wins, so scan from the far end downward.
    always_comb begin
        int unsigned idx;
        idx          = 0;
        w_winner     = '0;
        w_has_winner = 1'b0;
        if (r_state == HOLD) begin
            w_winner     = r_lock_id;
            w_has_winner = 1'b1;
        end else begin
            for (int i = NumMasters - 1; i >= 0; i--) begin
                idx = (int'(r_ptr) + i) % NumMasters;
                if (master_req_i[idx].req) begin
                    w_winner     = IdW'(idx);
                    w_has_winner = 1'b1;
                end
            end
        end
    end

    // No bypass: a full FIFO blocks even when a response pops this cycle.
    always_comb begin
        slave_req_o = '0;
        if (w_has_winner && !w_full && !rst_i) begin
            slave_req_o = master_req_i[w_winner];
        end
    end

    assign w_hs = slave_req_o.req & slave_resp_i.gnt;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ARB:     if (slave_req_o.req && !slave_resp_i.gnt) w_state_next = HOLD;
            HOLD:    if (w_hs) w_state_next = ARB;
            default: w_state_next = ARB;
        endcase
    end

    assign w_weight     = weight_i[int'(w_winner)*WeightWidth +: WeightWidth];
    assign w_credit_use = (w_winner == r_ptr && r_credit != '0)
                        ? r_credit
                        : WeightWidth'(eff_weight(32'(w_weight)));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= ARB;
            r_ptr     <= '0;
            r_credit  <= '0;
            r_lock_id <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (r_state == ARB && slave_req_o.req && !slave_resp_i.gnt) begin
                r_lock_id <= w_winner;
            end
            if (w_hs) begin
                if (w_credit_use == WeightWidth'(1)) begin
                    r_ptr    <= (int'(w_winner) == NumMasters - 1) ? '0 : w_winner + 1'b1;
                    r_credit <= '0;
                end else begin
                    r_ptr    <= w_winner;
                    r_credit <= w_credit_use - 1'b1;
                end
            end
            if (slave_resp_i.rvalid && w_empty) begin
                r_err <= 1'b1;
            end
        end
    end

    obi_arb_id_fifo #(
        .Width (IdW),
        .Depth (MaxOutstanding)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (w_hs),
        .data_i  (w_winner),
        .pop_i   (slave_resp_i.rvalid),
        .data_o  (w_head),
        .full_o  (w_full),
        .empty_o (w_empty),
        .count_o (w_count)
    );

    always_comb begin
        master_resp_o = '0;
        for (int i = 0; i < NumMasters; i++) begin
            master_resp_o[i].gnt    = w_hs && (w_winner == IdW'(i));
            master_resp_o[i].rvalid = slave_resp_i.rvalid && !w_empty && (w_head == IdW'(i));
            master_resp_o[i].rdata  = slave_resp_i.rdata;
        end
    end

    assign busy_o = (w_count != '0) || (r_state == HOLD);
    assign err_o  = r_err;

`ifdef OBI_WRR_ARBITER_PERF_CNT_EN
    genvar gi;
    generate
        for (gi = 0; gi < NumMasters; gi++) begin : g_perf_cnt
            logic [31:0] r_cnt;
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    r_cnt <= '0;
                end else if (w_hs && w_winner == IdW'(gi)) begin
                    r_cnt <= r_cnt + 32'd1;
                end
            end
            assign grant_cnt_o[gi*32 +: 32] = r_cnt;
        end
    endgenerate
`endif

endmodule

// File: tb/tb_obi_wrr_arbiter.sv
// Scoreboard bench: stimulus queues expected grants/responses, a monitor pops on DUT outputs.
module tb_obi_wrr_arbiter;
    import obi_pkg::*;

    localparam int N  = 3;
    localparam int WW = 4;

    logic                  clk = 1'b0;
    logic                  rst_i;
    logic [N*WW-1:0]       weight_i;
    obi_req_t  [N-1:0]     master_req_i;
    obi_resp_t [N-1:0]     master_resp_o;
    obi_req_t              slave_req_o;
    obi_resp_t             slave_resp_i;
    logic                  busy_o;
    logic                  err_o;
`ifdef OBI_WRR_ARBITER_PERF_CNT_EN
    logic [N*32-1:0]       grant_cnt_o;
`endif

    obi_wrr_arbiter #(
        .NumMasters     (N),
        .MaxOutstanding (4),
        .WeightWidth    (WW)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .weight_i      (weight_i),
        .master_req_i  (master_req_i),
        .master_resp_o (master_resp_o),
        .slave_req_o   (slave_req_o),
        .slave_resp_i  (slave_resp_i),
        .busy_o        (busy_o),
        .err_o         (err_o)
`ifdef OBI_WRR_ARBITER_PERF_CNT_EN
        ,
        .grant_cnt_o   (grant_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          exp_gnt_q[$];
    int          exp_rsp_m_q[$];
    logic [31:0] exp_rsp_d_q[$];
    int          exp_order[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end else begin
            $display("ok   %s: %0h (t=%0t)", name, act, $time);
        end
    endtask

    // Monitor: every master gnt/rvalid must match the head of its expectation queue.
    always @(negedge clk) begin
        if (rst_i === 1'b0) begin
            for (int m = 0; m < N; m++) begin
                if (master_resp_o[m].gnt) begin
                    if (exp_gnt_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_gnt: master %0d granted, none expected (t=%0t)", m, $time);
                    end else begin
                        automatic int e = exp_gnt_q.pop_front();
                        check("grant_master", 32'(m), 32'(e));
                    end
                end
                if (master_resp_o[m].rvalid) begin
                    if (exp_rsp_m_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_rvalid: master %0d got rvalid, none expected (t=%0t)", m, $time);
                    end else begin
                        automatic int          em = exp_rsp_m_q.pop_front();
                        automatic logic [31:0] ed = exp_rsp_d_q.pop_front();
                        check("rsp_master", 32'(m), 32'(em));
                        check("rsp_rdata", master_resp_o[m].rdata, ed);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic set_req(input int m, input logic r);
        master_req_i[m].req   = r;
        master_req_i[m].we    = 1'b0;
        master_req_i[m].be    = 4'hF;
        master_req_i[m].addr  = 32'h1000 + 32'(m) * 32'h100;
        master_req_i[m].wdata = 32'hC0DE_0000 + 32'(m);
    endtask

    task automatic exp_gnt(input int m);
        exp_gnt_q.push_back(m);
    endtask

    task automatic exp_rsp(input int m, input logic [31:0] d);
        exp_rsp_m_q.push_back(m);
        exp_rsp_d_q.push_back(d);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        for (int m = 0; m < N; m++) set_req(m, 1'b0);
        slave_resp_i = '0;
        #1;
        check("rst_slave_req", 32'(slave_req_o.req), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        step();
        step();
        rst_i = 1'b0;
    endtask

    // Continuous requests from all masters, gnt every cycle, each rvalid one cycle after its grant.
    task automatic run_stream(input int n);
        for (int m = 0; m < N; m++) set_req(m, 1'b1);
        for (int k = 0; k < n; k++) begin
            slave_resp_i.gnt    = 1'b1;
            slave_resp_i.rvalid = (k > 0);
            slave_resp_i.rdata  = 32'h100 + 32'(k) - 32'd1;
            exp_gnt(exp_order[k]);
            exp_rsp(exp_order[k], 32'h100 + 32'(k));
            step();
        end
        for (int m = 0; m < N; m++) set_req(m, 1'b0);
        slave_resp_i.gnt    = 1'b0;
        slave_resp_i.rvalid = 1'b1;
        slave_resp_i.rdata  = 32'h100 + 32'(n) - 32'd1;
        step();
        slave_resp_i.rvalid = 1'b0;
        sample();
        check("stream_busy_idle", 32'(busy_o), 32'd0);
        step();
    endtask

    initial begin
        rst_i        = 1'b1;
        weight_i     = '0;
        master_req_i = '0;
        slave_resp_i = '0;

        // Weights {3,1,1}: order 0,0,0,1,2 repeating.
        weight_i = {4'd1, 4'd1, 4'd3};
        do_reset();
        exp_order = '{0, 0, 0, 1, 2, 0, 0, 0, 1, 2};
        run_stream(10);

        // M1 held unacknowledged; late M0 must not steal the locked slot.
        weight_i = {4'd1, 4'd1, 4'd1};
        do_reset();
        set_req(1, 1'b1);
        sample();
        check("hold_addr_c1", slave_req_o.addr, 32'h1100);
        step();
        set_req(0, 1'b1);
        sample();
        check("hold_addr_c2", slave_req_o.addr, 32'h1100);
        check("hold_busy", 32'(busy_o), 32'd1);
        step();
        sample();
        check("hold_addr_c3", slave_req_o.addr, 32'h1100);
        step();
        slave_resp_i.gnt = 1'b1;
        exp_gnt(1);
        sample();
        check("hold_addr_c4", slave_req_o.addr, 32'h1100);
        step();
        set_req(1, 1'b0);
        exp_gnt(0);
        sample();
        check("next_addr_m0", slave_req_o.addr, 32'h1000);
        step();
        set_req(0, 1'b0);
        slave_resp_i.gnt = 1'b0;

        // FIFO full blocks the fifth request, even across a same-cycle pop.
        do_reset();
        set_req(0, 1'b1);
        set_req(2, 1'b1);
        slave_resp_i.gnt = 1'b1;
        exp_order = '{0, 2, 0, 2};
        for (int k = 0; k < 4; k++) begin
            exp_gnt(exp_order[k]);
            step();
        end
        sample();
        check("full_blocked", 32'(slave_req_o.req), 32'd0);
        check("full_busy", 32'(busy_o), 32'd1);
        step();
        slave_resp_i.rvalid = 1'b1;
        slave_resp_i.rdata  = 32'hD0;
        exp_rsp(0, 32'hD0);
        sample();
        check("full_no_bypass", 32'(slave_req_o.req), 32'd0);
        step();
        slave_resp_i.rvalid = 1'b0;
        exp_gnt(0);
        sample();
        check("full_unblocked", 32'(slave_req_o.req), 32'd1);
        step();
        set_req(0, 1'b0);
        set_req(2, 1'b0);
        slave_resp_i.gnt = 1'b0;

        // Grants M2, M0, M1 then in-order responses A, B, C.
        do_reset();
        slave_resp_i.gnt = 1'b1;
        set_req(2, 1'b1);
        exp_gnt(2);
        step();
        set_req(2, 1'b0);
        set_req(0, 1'b1);
        exp_gnt(0);
        step();
        set_req(0, 1'b0);
        set_req(1, 1'b1);
        exp_gnt(1);
        step();
        set_req(1, 1'b0);
        slave_resp_i.gnt    = 1'b0;
        slave_resp_i.rvalid = 1'b1;
        slave_resp_i.rdata  = 32'hA;
        exp_rsp(2, 32'hA);
        step();
        slave_resp_i.rdata = 32'hB;
        exp_rsp(0, 32'hB);
        step();
        slave_resp_i.rdata = 32'hC;
        exp_rsp(1, 32'hC);
        step();
        slave_resp_i.rvalid = 1'b0;
        sample();
        check("route_busy_idle", 32'(busy_o), 32'd0);
        step();

        // Stray rvalid sets sticky err; reset mid-HOLD clears everything.
        do_reset();
        slave_resp_i.rvalid = 1'b1;
        slave_resp_i.rdata  = 32'hEE;
        sample();
        check("err_before", 32'(err_o), 32'd0);
        step();
        slave_resp_i.rvalid = 1'b0;
        sample();
        check("err_set", 32'(err_o), 32'd1);
        step();
        sample();
        check("err_sticky", 32'(err_o), 32'd1);
        step();
        set_req(0, 1'b1);
        slave_resp_i.gnt = 1'b1;
        exp_gnt(0);
        step();
        set_req(0, 1'b0);
        set_req(2, 1'b1);
        slave_resp_i.gnt = 1'b0;
        sample();
        check("lock_addr_m2", slave_req_o.addr, 32'h1200);
        step();
        sample();
        check("lock_busy", 32'(busy_o), 32'd1);
        #2;
        rst_i = 1'b1;
        #1;
        check("async_rst_req", 32'(slave_req_o.req), 32'd0);
        check("async_rst_busy", 32'(busy_o), 32'd0);
        check("async_rst_err", 32'(err_o), 32'd0);
        check("async_rst_gnt2", 32'(master_resp_o[2].gnt), 32'd0);
        step();
        rst_i = 1'b0;
        set_req(2, 1'b0);
        slave_resp_i.rvalid = 1'b1;
        slave_resp_i.rdata  = 32'hF0;
        step();
        slave_resp_i.rvalid = 1'b0;
        sample();
        check("inflight_err", 32'(err_o), 32'd1);
        step();
        set_req(0, 1'b1);
        set_req(2, 1'b1);
        slave_resp_i.gnt = 1'b1;
        exp_gnt(0);
        step();
        set_req(0, 1'b0);
        set_req(2, 1'b0);
        slave_resp_i.gnt    = 1'b0;
        slave_resp_i.rvalid = 1'b1;
        slave_resp_i.rdata  = 32'hF1;
        exp_rsp(0, 32'hF1);
        step();
        slave_resp_i.rvalid = 1'b0;
        step();

`ifdef OBI_WRR_ARBITER_PERF_CNT_EN
        // Zero weights behave as one: plain round-robin, 10 grants -> {4,3,3}.
        weight_i = '0;
        do_reset();
        exp_order = '{0, 1, 2, 0, 1, 2, 0, 1, 2, 0};
        run_stream(10);
        sample();
        check("perf_cnt_m0", grant_cnt_o[0*32 +: 32], 32'd4);
        check("perf_cnt_m1", grant_cnt_o[1*32 +: 32], 32'd3);
        check("perf_cnt_m2", grant_cnt_o[2*32 +: 32], 32'd3);
        step();
`endif

        step();
        check("gnt_queue_drained", 32'(exp_gnt_q.size()), 32'd0);
        check("rsp_queue_drained", 32'(exp_rsp_m_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
